// File: rtl/mpy_csa_accum.sv
// Resolves the multiplier's carry-save pair and accumulates products per frame, emitting a scaled, saturated result.
// Latency: 2 cycles from input to out_valid (stage 1 resolves the product, stage 2 accumulates and registers the result).
// Backpressure: none; one product per clock is accepted unconditionally and the consumer must sample on o_out_valid.
module mpy_csa_accum #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic             i_in_last,
    input  logic [15:0]      i_csa_a,
    input  logic [15:0]      i_csa_b,
    input  logic             i_prod_signed,
    input  logic             i_flush,
    output logic             o_out_valid,
    output logic [OUT_W-1:0] o_out_data,
    output logic [ACC_W-1:0] o_out_acc,
    output logic             o_out_ovf,
    output logic [7:0]       o_out_taps
);

    // Stage 1 registers
    logic [15:0]      r_p1;
    logic             r_v1;
    logic             r_last1;
    logic             r_sgn1;

    // Stage 2 state
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_tap;
    logic             r_first;

    // Combinational paths
    logic [15:0]              w_sum;
    logic [ACC_W-1:0]         w_ext;
    logic [ACC_W-1:0]         w_acc_nxt;
    logic [7:0]               w_tap_nxt;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [ACC_W-OUT_W:0]     w_hi;
    logic                     w_ovf;
    logic [OUT_W-1:0]         w_sat;
    logic                     w_close;

    // Carry out of bit 15 is intentionally dropped: the CSA pair always sums to a 16-bit product.
    assign w_sum = i_csa_a + i_csa_b;

    assign w_ext     = r_sgn1 ? {{(ACC_W-16){r_p1[15]}}, r_p1}
                              : {{(ACC_W-16){1'b0}}, r_p1};
    assign w_acc_nxt = (r_first ? '0 : r_acc) + w_ext;
    assign w_tap_nxt = r_first ? 8'd1 : ((r_tap == 8'hFF) ? 8'hFF : r_tap + 8'd1);
    assign w_close   = r_v1 & r_last1;

    // Saturation: the shifted value fits in OUT_W bits only when every bit from OUT_W-1 up is a copy of the sign.
    assign w_shifted = $signed(w_acc_nxt) >>> SHIFT;
    assign w_hi      = w_shifted[ACC_W-1:OUT_W-1];
    assign w_ovf     = ~((&w_hi) | ~(|w_hi));
    assign w_sat     = w_ovf ? (w_shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                   : {1'b0, {(OUT_W-1){1'b1}}})
                             : w_shifted[OUT_W-1:0];

    // Stage 1: capture the resolved product; a flush drops whatever is entering this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1    <= 1'b0;
            r_p1    <= '0;
            r_last1 <= 1'b0;
            r_sgn1  <= 1'b0;
        end else if (i_flush) begin
            r_v1    <= 1'b0;
        end else begin
            r_v1 <= i_in_valid;
            if (i_in_valid) begin
                r_p1    <= w_sum;
                r_last1 <= i_in_last;
                r_sgn1  <= i_prod_signed;
            end
        end
    end

    // Stage 2: accumulate and count taps; closing a frame re-arms r_first so the next product starts from 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_tap   <= '0;
            r_first <= 1'b1;
        end else if (i_flush) begin
            r_acc   <= '0;
            r_tap   <= '0;
            r_first <= 1'b1;
        end else if (r_v1) begin
            r_acc   <= w_acc_nxt;
            r_tap   <= w_tap_nxt;
            r_first <= r_last1;
        end
    end

    // Result registers: pulse valid on frame close, otherwise hold the last frame's fields (flush included).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_acc   <= '0;
            o_out_ovf   <= 1'b0;
            o_out_taps  <= '0;
        end else if (i_flush) begin
            o_out_valid <= 1'b0;
        end else begin
            o_out_valid <= w_close;
            if (w_close) begin
                o_out_data <= w_sat;
                o_out_acc  <= w_acc_nxt;
                o_out_ovf  <= w_ovf;
                o_out_taps <= w_tap_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mpy_csa_accum.sv
module tb_mpy_csa_accum;

    localparam int ACC_W = 24;
    localparam int OUT_W = 16;
    localparam int SHIFT = 0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_last, prod_signed, flush;
    logic [15:0]      csa_a, csa_b;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic [7:0]       out_taps;

    always #5 clk = ~clk;

    mpy_csa_accum #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_last(in_last),
        .i_csa_a(csa_a), .i_csa_b(csa_b), .i_prod_signed(prod_signed), .i_flush(flush),
        .o_out_valid(out_valid), .o_out_data(out_data), .o_out_acc(out_acc),
        .o_out_ovf(out_ovf), .o_out_taps(out_taps)
    );

    typedef struct {
        logic        v, l, s, f;
        logic [15:0] a, b;
        logic        ev;
        logic [15:0] ed;
        logic [23:0] ea;
        logic        eo;
        logic [7:0]  et;
    } vec_t;

    typedef struct {
        int unsigned cyc;
        logic [15:0] d;
        logic [23:0] a;
        logic        o;
        logic [7:0]  t;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          n_pulse = 0;
    int          n_push  = 0;
    int unsigned cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic v, input logic l, input logic s, input logic f,
                                input logic [15:0] a, input logic [15:0] b, input logic ev,
                                input logic [15:0] ed, input logic [23:0] ea,
                                input logic eo, input logic [7:0] et);
        vec_t x;
        x.v = v; x.l = l; x.s = s; x.f = f; x.a = a; x.b = b;
        x.ev = ev; x.ed = ed; x.ea = ea; x.eo = eo; x.et = et;
        return x;
    endfunction

    // Drive one cycle of stimulus just after a rising edge; frame-closing products push their expected result.
    task automatic drive(input vec_t x);
        exp_t e;
        in_valid = x.v; in_last = x.l; prod_signed = x.s; flush = x.f;
        csa_a = x.a; csa_b = x.b;
        if (x.ev && x.v && !x.f) begin
            e.cyc = cyc + 2; e.d = x.ed; e.a = x.ea; e.o = x.eo; e.t = x.et;
            sb.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(mk(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 24'h0, 0, 8'h0));
    endtask

    // Monitor: every out_valid pulse must match the oldest expected frame, including its arrival cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (out_valid === 1'b1) begin
            n_pulse++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out_valid: got pulse at cycle %0d, want none", cyc);
            end else begin
                e = sb.pop_front();
                chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_acc", 32'(out_acc), 32'(e.a));
                chk("out_ovf", 32'(out_ovf), 32'(e.o));
                chk("out_taps", 32'(out_taps), 32'(e.t));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 0; in_last = 0; prod_signed = 0; flush = 0;
        csa_a = 0; csa_b = 0;

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom); in_last = 1'($urandom); prod_signed = 1'($urandom);
            csa_a = 16'($urandom); csa_b = 16'($urandom); flush = 1'($urandom);
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        end
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_acc", 32'(out_acc), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_out_taps", 32'(out_taps), 32'd0);
        in_valid = 0; in_last = 0; prod_signed = 0; flush = 0; csa_a = 0; csa_b = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(10);
        chk("idle_no_pulse", 32'(n_pulse), 32'd0);

        // Vector table: v l s f a b | ev ed ea eo et
        tbl.push_back(mk(1, 1, 0, 0, 16'h00C8, 16'h0064, 1, 16'h012C, 24'h00012C, 0, 8'd1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0,    16'h0,    0, 16'h0,    24'h0,      0, 8'd0));
        tbl.push_back(mk(1, 0, 1, 0, 16'hFFFF, 16'hFFFD, 0, 16'h0,    24'h0,      0, 8'd0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0,    16'h0,    0, 16'h0,    24'h0,      0, 8'd0));
        tbl.push_back(mk(1, 0, 1, 0, 16'hFFFF, 16'hFFFD, 0, 16'h0,    24'h0,      0, 8'd0));
        tbl.push_back(mk(1, 1, 1, 0, 16'hFFFF, 16'hFFFD, 1, 16'hFFF4, 24'hFFFFF4, 0, 8'd3));
        tbl.push_back(mk(1, 0, 0, 0, 16'h7FFF, 16'h0000, 0, 16'h0,    24'h0,      0, 8'd0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h7FFF, 16'h0000, 0, 16'h0,    24'h0,      0, 8'd0));
        tbl.push_back(mk(1, 1, 0, 0, 16'h7FFF, 16'h0000, 1, 16'h7FFF, 24'h017FFD, 1, 8'd3));
        tbl.push_back(mk(1, 0, 1, 0, 16'h8000, 16'h0000, 0, 16'h0,    24'h0,      0, 8'd0));
        tbl.push_back(mk(1, 1, 1, 0, 16'h8000, 16'h0000, 1, 16'h8000, 24'hFF0000, 1, 8'd2));
        // Carry out of bit 15 dropped: 0xFFFF + 0x0002 -> 0x0001
        tbl.push_back(mk(1, 1, 0, 0, 16'hFFFF, 16'h0002, 1, 16'h0001, 24'h000001, 0, 8'd1));
        // Back-to-back frames {10, 20, last} {5, last}
        tbl.push_back(mk(1, 0, 0, 0, 16'd4,    16'd6,    0, 16'h0,    24'h0,      0, 8'd0));
        tbl.push_back(mk(1, 1, 0, 0, 16'd20,   16'd0,    1, 16'd30,   24'd30,     0, 8'd2));
        tbl.push_back(mk(1, 1, 0, 0, 16'd2,    16'd3,    1, 16'd5,    24'd5,      0, 8'd1));
        foreach (tbl[i]) drive(tbl[i]);
        idle(3);

        // Flush in the same cycle as the closing product: no result, outputs hold the previous frame
        drive(mk(1, 0, 0, 0, 16'd100, 16'd0, 0, 16'h0, 24'h0, 0, 8'd0));
        drive(mk(1, 0, 0, 0, 16'd200, 16'd0, 0, 16'h0, 24'h0, 0, 8'd0));
        drive(mk(1, 1, 0, 1, 16'd300, 16'd0, 0, 16'h0, 24'h0, 0, 8'd0));
        idle(3);
        chk("flush_hold_data", 32'(out_data), 32'd5);
        chk("flush_hold_taps", 32'(out_taps), 32'd1);
        drive(mk(1, 1, 0, 0, 16'd7, 16'd0, 1, 16'd7, 24'd7, 0, 8'd1));
        idle(3);

        // Reset pulsed mid-frame: frame discarded, outputs return to reset values
        drive(mk(1, 0, 0, 0, 16'd100, 16'd0, 0, 16'h0, 24'h0, 0, 8'd0));
        drive(mk(1, 0, 0, 0, 16'd200, 16'd0, 0, 16'h0, 24'h0, 0, 8'd0));
        rst_n = 1'b0;
        in_valid = 0; in_last = 0;
        @(negedge clk);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_out_taps", 32'(out_taps), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(mk(1, 1, 0, 0, 16'd7, 16'd0, 1, 16'd7, 24'd7, 0, 8'd1));
        idle(3);

        // Tap counter saturates at 255 on a 300-product frame
        for (int i = 0; i < 300; i++)
            drive(mk(1, (i == 299), 0, 0, 16'd1, 16'd0, (i == 299), 16'h012C, 24'h00012C, 0, 8'd255));

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("pulse_count", 32'(n_pulse), 32'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mpy_csa_accum.md
# mpy_csa_accum

Downstream stage of the 8x8 Booth/Wallace multiplier. Takes the multiplier's carry-save pair, resolves it into a 16-bit product and accumulates products over a frame (one FIR output or dot product). At frame end it emits a scaled, saturated result. Two-stage pipeline; one product accepted per cycle with no stalls.

## Interface

- ACC_W, 24, accumulator width (at least 17)
- OUT_W, 16, output width (at most ACC_W)
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0 to ACC_W-OUT_W)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  csa_a/csa_b/prod_signed/in_last valid this cycle
- in_last  in  1  this product closes the frame
- csa_a  in  16  carry-save word A from multiplier
- csa_b  in  16  carry-save word B from multiplier
- prod_signed  in  1  product is two's complement (signed_MPD | signed_MPR)
- flush  in  1  synchronous abort of the current frame
- out_valid  out  1  one-cycle pulse, result fields valid
- out_data  out  OUT_W  saturated, shifted frame result
- out_acc  out  ACC_W  raw accumulator value at frame end
- out_ovf  out  1  out_data was saturated
- out_taps  out  8  number of products in the frame (saturates at 255)

## Operation

- Stage 1, registered when in_valid=1: p1 = (csa_a + csa_b) mod 2^16, plus v1, last1 and sgn1. The carry out of bit 15 is discarded.
- Stage 2, when v1=1:
  - ext = sign-extend p1 to ACC_W if sgn1, else zero-extend.
  - acc <= (first ? 0 : acc) + ext, modulo 2^ACC_W. The accumulator wraps; it does not saturate internally.
- first flag: set to 1 at reset, after flush, and on every stage-2 update with last1=1. Cleared on any other stage-2 update.
- Tap counter: tap_cnt <= (first ? 1 : min(tap_cnt+1, 255)) on each stage-2 update.
- Frame close (stage-2 update with last1=1):
  - s = new acc >>> SHIFT (arithmetic shift).
  - out_data = s clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_ovf = 1 iff clamping occurred.
  - out_acc = new acc; out_taps = new tap count; out_valid = 1 for that cycle.
- out_data, out_acc, out_ovf and out_taps hold their values until the next frame close.
- in_valid=0 cycles (bubbles) advance the pipeline with nothing accumulated; frames may contain gaps.
- A frame of one product (in_valid and in_last together on a fresh frame) is legal.
- flush=1 at a clock edge:
  - clears v1, acc and tap_cnt to 0; sets first to 1; forces out_valid to 0.
  - any input presented that cycle and any product in stage 1 are dropped.
  - out_data, out_acc, out_ovf and out_taps hold.
- Simultaneous frame close in stage 2 and new product in stage 1: both proceed. The new product starts the next frame with acc base 0.

## Timing

- Reset values: out_valid=0, out_data=0, out_acc=0, out_ovf=0, out_taps=0; internally acc=0, tap_cnt=0, v1=0, first=1.
- rst_n deassertion mid-frame discards the frame entirely; no partial result is emitted.
- Latency: input sampled at edge k -> product registered at edge k+1 -> accumulated at edge k+2. For the last product, out_valid is high for the cycle following edge k+2.
- Throughput: one product per clock, sustained indefinitely.
- Frames of length 1 issued back to back produce out_valid on consecutive cycles.
- No backpressure: the consumer must sample on out_valid.

## Test plan

- Reset: hold rst_n=0 while toggling inputs -> all outputs 0. Release, then drive in_valid=0 for 10 cycles -> out_valid stays 0.
- Single-product frame, unsigned: csa_a=0x00C8, csa_b=0x0064, in_last=1 at edge k -> at k+2: out_valid=1, out_data=0x012C, out_acc=0x00012C, out_taps=1, out_ovf=0.
- Signed frame of 3 with one bubble: csa_a=0xFFFF, csa_b=0xFFFD, prod_signed=1, each product -4 -> out_acc=0xFFFFF4, out_data=0xFFF4, out_taps=3, out_ovf=0.
- Saturation (SHIFT=0):
  - 3 unsigned products of 0x7FFF -> out_acc=0x017FFD, out_data=0x7FFF, out_ovf=1.
  - 2 signed products of 0x8000 -> out_acc=0xFF0000, out_data=0x8000, out_ovf=1.
- Back-to-back frames: frame A = {10, 20, last}, followed with no gap by frame B = {5, last} -> two out_valid pulses one cycle apart, out_data 30 then 5, out_taps 2 then 1.
- Aborts:
  - Frame {100, 200}, then flush in the same cycle as product 300 (with in_last) -> no out_valid. The next frame {7, last} gives out_data=7, out_taps=1.
  - Repeat with rst_n pulsed low mid-frame instead of flush -> same required result.
